// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the sequential radix-4 Booth
//               multiplier: default operand width, iteration count, FSM
//               state encoding and Booth partial-product select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = MULT_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_sel_t;

  // Radix-4 Booth recoding of {b[i+1], b[i], b[i-1]}.
  function automatic booth_sel_t booth_recode(input logic [2:0] bits);
    booth_sel_t sel;
    case (bits)
      3'b001, 3'b010: sel = PM;
      3'b011:         sel = P2M;
      3'b100:         sel = N2M;
      3'b101, 3'b110: sel = NM;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/booth_r4_sel.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_sel
// Description : Combinational radix-4 Booth partial-product selector.
//               Recodes three multiplier bits and returns 0, +M, +2M, -M or
//               -2M at WIDTH+2 bits so that M = -2^(WIDTH-1) stays exact.
// Ports       : i_bits  [2:0]       recoded bits {lo[1], lo[0], guard}
//               i_mcand [WIDTH+1:0] sign-extended multiplicand
//               o_pp    [WIDTH+1:0] selected partial product
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_sel
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2:0]       i_bits,
  input  logic [WIDTH+1:0] i_mcand,
  output logic [WIDTH+1:0] o_pp
);

  booth_sel_t w_sel;

  assign w_sel = booth_recode(i_bits);

  always_comb begin
    o_pp = '0;
    case (w_sel)
      PM:      o_pp = i_mcand;
      P2M:     o_pp = i_mcand << 1;
      NM:      o_pp = -i_mcand;
      N2M:     o_pp = -(i_mcand << 1);
      default: o_pp = '0;
    endcase
  end

endmodule : booth_r4_sel
`default_nettype wire

// File: rtl/mult_booth_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_booth_seq
// Description : Multi-cycle signed WIDTH x WIDTH multiplier, radix-4 Booth,
//               one step per clock, fixed WIDTH/2-cycle latency. Start/ready
//               timing matches the companion iterative divider.
// Ports       : clk        rising-edge clock
//               reset      asynchronous active-high reset
//               ctrl_MULT  start pulse, operands sampled on the same edge
//               mcand      multiplicand (two's complement)
//               mplier     multiplier (two's complement)
//               prod       low WIDTH bits of the product (held)
//               prod_hi    high WIDTH bits of the product (MULT_HI_WORD_EN)
//               exceptRes  product does not fit in WIDTH signed bits (held)
//               resultRDY  one-cycle completion pulse
//               busy       high while iterating
// Options     : `define MULT_HI_WORD_EN to add the prod_hi output.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] prod,
`ifdef MULT_HI_WORD_EN
  output logic [WIDTH-1:0] prod_hi,
`endif
  output logic             exceptRes,
  output logic             resultRDY,
  output logic             busy
);

  localparam int ITERS = WIDTH / 2;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITERS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_guard;
  logic [WIDTH+1:0]   r_mcand;

  logic [WIDTH+1:0]   w_pp;
  logic [WIDTH+1:0]   w_sum;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [WIDTH:0]     w_top;
  logic               w_ovf;

  booth_r4_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .i_bits  ({r_lo[1:0], r_guard}),
    .i_mcand (r_mcand),
    .o_pp    (w_pp)
  );

  // hi is sign-extended into the WIDTH+2 adder. The accumulated value divided
  // by 4 always fits back into WIDTH bits, so keeping only sum[WIDTH+1:2] as
  // the next hi is the exact arithmetic shift.
  assign w_sum    = {{2{r_hi[WIDTH-1]}}, r_hi} + w_pp;
  assign w_hi_nxt = w_sum[WIDTH+1:2];
  assign w_lo_nxt = {w_sum[1:0], r_lo[WIDTH-1:2]};

  // Product fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
  assign w_top = {w_hi_nxt, w_lo_nxt[WIDTH-1]};
  assign w_ovf = !((&w_top) || !(|w_top));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_guard   <= 1'b0;
      r_mcand   <= '0;
      prod      <= '0;
`ifdef MULT_HI_WORD_EN
      prod_hi   <= '0;
`endif
      exceptRes <= 1'b0;
      resultRDY <= 1'b0;
      busy      <= 1'b0;
    end else begin
      resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        // Start from any state: a start in RUN silently abandons the current
        // operation; a start in DONE overlaps the completion pulse.
        r_state <= RUN;
        r_cnt   <= '0;
        r_hi    <= '0;
        r_lo    <= mplier;
        r_guard <= 1'b0;
        r_mcand <= {{2{mcand[WIDTH-1]}}, mcand};
        busy    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          RUN: begin
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_guard <= r_lo[1];
            if (r_cnt == c_LAST) begin
              r_state   <= DONE;
              resultRDY <= 1'b1;
              busy      <= 1'b0;
              prod      <= w_lo_nxt;
`ifdef MULT_HI_WORD_EN
              prod_hi   <= w_hi_nxt;
`endif
              exceptRes <= w_ovf;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : mult_booth_seq
`default_nettype wire

// File: doc/mult_booth_seq.md
Name: mult_booth_seq

Overview:
- Multi-cycle signed 32x32 multiplier. It is the forward-direction companion to the team's iterative signed divider.
- Shares the divider's start/result conventions: a single-cycle ctrl pulse launches an operation, then the block iterates over a 64-bit product register and returns a 32-bit result plus an exception flag.
- Sits beside the divider in the ALU multdiv unit. The two have the same issue/ready timing, so the issue logic treats them identically.

Parameters:
- WIDTH, 32, operand and result width. Must be even.
- ITERS, WIDTH/2, number of radix-4 Booth iterations (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ctrl_MULT  in  1  start pulse; operands sampled on the same edge.
- mcand  in  WIDTH  multiplicand, two's complement.
- mplier  in  WIDTH  multiplier, two's complement.
- prod  out  WIDTH  low WIDTH bits of the signed product.
- exceptRes  out  1  overflow: the product does not fit in WIDTH signed bits.
- resultRDY  out  1  one-cycle pulse; prod and exceptRes are valid from this cycle on.
- busy  out  1  high while iterating.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Reset forces state to IDLE, and forces prod, exceptRes, resultRDY, busy, the counter and the product register to 0.
- States:
  - IDLE: waiting. ctrl_MULT=1 -> RUN.
  - RUN: one radix-4 Booth step per cycle. The counter goes 0..ITERS-1; the step at count ITERS-1 -> DONE.
  - DONE: resultRDY=1 for exactly this cycle, then -> IDLE, unless ctrl_MULT=1, which goes -> RUN.
- Start edge (edge 0), on ctrl_MULT=1:
  - Load the product register {hi=0, lo=mplier, guard=0}.
  - Latch mcand sign-extended to WIDTH+2 bits.
  - Clear the counter and set busy=1.
- Each RUN step:
  - Recode bits {lo[1:0],guard} to a partial product of 0, +M, +2M, -M or -2M.
  - Add it to hi, using a WIDTH+2-bit signed add.
  - Arithmetic shift right by 2 across {hi,lo,guard}.
- Latency: edges 1..ITERS perform the steps. After edge ITERS: state=DONE, resultRDY=1, busy=0, and prod/exceptRes are updated.
  - For WIDTH=32, resultRDY is high in the cycle after edge 16.
- Result:
  - prod = product[WIDTH-1:0].
  - exceptRes = 1 iff product[2*WIDTH-1:WIDTH-1] is not all-equal (signed overflow).
- Output hold: prod and exceptRes keep their values until the next completion or reset. They do not change during RUN.
- ctrl_MULT during RUN: abort the current operation and restart with the new operands. The counter is cleared and no resultRDY is issued for the aborted operation.
- ctrl_MULT in DONE: resultRDY still pulses for the completed operation, and the new operation starts on the same edge.
- Reset mid-RUN: immediate abort, no resultRDY, all outputs 0.
- Operand changes after the start edge are ignored.
- Corner operands: mcand = -2^(WIDTH-1) must be exact. This is why the internal add is WIDTH+2 bits wide.
- Zero operands: no early termination. The fixed ITERS-cycle latency is kept.

Optional Feature:
- MULT_HI_WORD_EN defined:
  - Adds output port prod_hi [WIDTH-1:0] = product[2*WIDTH-1:WIDTH].
  - prod_hi is updated and held with prod, and reset to 0.
  - exceptRes is unchanged.
- Undefined: no prod_hi port, and the upper product word is not retained after DONE. Timing and all other outputs are identical.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - WIDTH default and ITERS;
  - Booth select codes (ZERO, PM, P2M, NM, N2M).
- One sub-module, booth_r4_sel: combinational. Takes the 3 recoded bits and the WIDTH+2 multiplicand, and outputs the WIDTH+2 partial product.
- The state machine, counter, adder and shift stay in mult_booth_seq.

Test Plan:
- 7 x 6, single pulse -> resultRDY one cycle after edge 16; prod=42, exceptRes=0; busy high exactly 16 cycles.
- -3 x 5 -> prod=0xFFFFFFF1, exceptRes=0. 0x80000000 x 1 -> prod=0x80000000, exceptRes=0.
- 0x40000000 x 2 -> prod=0x80000000, exceptRes=1. 0x80000000 x 0xFFFFFFFF -> prod=0x80000000, exceptRes=1 (with MULT_HI_WORD_EN: prod_hi=0x00000000).
- Start 100 x 100; at edge 8 pulse ctrl_MULT with 3 x 4 -> exactly one resultRDY, 16 cycles after the second pulse, with prod=12.
- Start 9 x 9; assert reset at edge 5 -> all outputs 0 immediately, no resultRDY; a following start with 2 x -2 gives prod=0xFFFFFFFC.
- Back-to-back: pulse ctrl_MULT in the DONE cycle -> resultRDY for the first operation and the second operation completes 16 cycles later; randomized 1000-vector compare against a 64-bit reference model.
